// File: rtl/parking_gate_controller_if.sv
// rtl/parking_gate_controller_if.sv - sensor and gate-command bundle for the parking gate controller
interface parking_gate_controller_if;
  logic entry_loop;
  logic entry_beam;
  logic exit_loop;
  logic exit_beam;
  logic parking_full;
  logic entry_gate_open;
  logic exit_gate_open;
  logic entry_event;
  logic exit_event;
  logic entry_denied;

  // Sensor/occupancy side drives the raw inputs and watches the commands
  modport master (
    output entry_loop, entry_beam, exit_loop, exit_beam, parking_full,
    input  entry_gate_open, exit_gate_open, entry_event, exit_event, entry_denied
  );

  // Controller side
  modport slave (
    input  entry_loop, entry_beam, exit_loop, exit_beam, parking_full,
    output entry_gate_open, exit_gate_open, entry_event, exit_event, entry_denied
  );
endinterface

// File: rtl/parking_gate_controller.sv
// rtl/parking_gate_controller.sv - two-lane parking barrier controller with sensor debouncing
module parking_gate_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db
);
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync1;
  logic       sync2;
  logic [7:0] cnt;

  // Two-flop synchronizer for the asynchronous sensor
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Count consecutive cycles the synchronized value disagrees; flip after DEBOUNCE_CYCLES of them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 8'd0;
      db  <= 1'b0;
    end else if (sync2 == db) begin
      cnt <= 8'd0;
    end else if (cnt == CNT_LAST) begin
      cnt <= 8'd0;
      db  <= sync2;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end
endmodule

module parking_gate_lane #(
  parameter int OPEN_TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic loop_db,
  input  logic beam_db,
  input  logic allow,
  output logic gate_open,
  output logic lane_event,
  output logic in_idle
);
  localparam int DW = $clog2(OPEN_TIMEOUT + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(OPEN_TIMEOUT - 1);
  localparam logic [DW-1:0] DWELL_MAX  = DW'(OPEN_TIMEOUT);

  typedef enum logic [1:0] {IDLE, OPEN, PASSING, CLOSING} lane_state_t;

  lane_state_t   state;
  logic [DW-1:0] dwell;

  assign in_idle = (state == IDLE);

  // Lane sequencing; gate command and event pulse are registered with the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gate_open  <= 1'b0;
      lane_event <= 1'b0;
      dwell      <= '0;
    end else begin
      lane_event <= 1'b0;
      case (state)
        IDLE: begin
          if (loop_db && allow) begin
            state     <= OPEN;
            gate_open <= 1'b1;
            dwell     <= '0;
          end
        end
        OPEN: begin
          if (dwell != DWELL_MAX) dwell <= dwell + 1'b1;
          if (beam_db) begin
            state <= PASSING;
          end else if (dwell == DWELL_LAST) begin
            // Vehicle never crossed the beam: close without counting it
            state     <= CLOSING;
            gate_open <= 1'b0;
          end
        end
        PASSING: begin
          if (!beam_db) begin
            state      <= CLOSING;
            gate_open  <= 1'b0;
            lane_event <= 1'b1;
          end
        end
        CLOSING: begin
          // Hold here until the loop clears so a lingering vehicle is counted once
          if (!loop_db) state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          gate_open <= 1'b0;
        end
      endcase
    end
  end
endmodule

module parking_gate_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int OPEN_TIMEOUT    = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  parking_gate_controller_if.slave bus
);
  logic entry_loop_db;
  logic entry_beam_db;
  logic exit_loop_db;
  logic exit_beam_db;
  logic entry_idle;
  logic exit_idle;
  logic entry_gate_open;
  logic exit_gate_open;
  logic entry_event;
  logic exit_event;
  logic entry_denied;

  parking_gate_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_entry_loop (
    .clk(clk), .rst(rst), .raw(bus.entry_loop), .db(entry_loop_db)
  );
  parking_gate_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_entry_beam (
    .clk(clk), .rst(rst), .raw(bus.entry_beam), .db(entry_beam_db)
  );
  parking_gate_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_exit_loop (
    .clk(clk), .rst(rst), .raw(bus.exit_loop), .db(exit_loop_db)
  );
  parking_gate_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_exit_beam (
    .clk(clk), .rst(rst), .raw(bus.exit_beam), .db(exit_beam_db)
  );

  // Entry lane only opens when the lot has room; the full flag is not looked at after opening
  parking_gate_lane #(.OPEN_TIMEOUT(OPEN_TIMEOUT)) u_entry (
    .clk(clk), .rst(rst), .loop_db(entry_loop_db), .beam_db(entry_beam_db),
    .allow(!bus.parking_full), .gate_open(entry_gate_open),
    .lane_event(entry_event), .in_idle(entry_idle)
  );

  // Exit lane always lets a vehicle out
  parking_gate_lane #(.OPEN_TIMEOUT(OPEN_TIMEOUT)) u_exit (
    .clk(clk), .rst(rst), .loop_db(exit_loop_db), .beam_db(exit_beam_db),
    .allow(1'b1), .gate_open(exit_gate_open),
    .lane_event(exit_event), .in_idle(exit_idle)
  );

  // Registered indication that a waiting entry vehicle is being turned away
  always_ff @(posedge clk or posedge rst) begin
    if (rst) entry_denied <= 1'b0;
    else     entry_denied <= entry_idle && entry_loop_db && bus.parking_full;
  end

  assign bus.entry_gate_open = entry_gate_open;
  assign bus.exit_gate_open  = exit_gate_open;
  assign bus.entry_event     = entry_event;
  assign bus.exit_event      = exit_event;
  assign bus.entry_denied    = entry_denied;
endmodule

// File: doc/parking_gate_controller.md
PARKING_GATE_CONTROLLER -- requirements
Module: parking_gate_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: number of consecutive stable synchronized samples before a debounced sensor changes value (legal range 1..255).
REQ-002 Parameter OPEN_TIMEOUT, default 1000: maximum cycles a gate stays in OPEN without the pass beam breaking (legal range 2..65535).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 entry_loop  input  1  raw asynchronous sensor, vehicle waiting at the entry gate.
REQ-006 entry_beam  input  1  raw asynchronous sensor, beam past the entry barrier broken.
REQ-007 exit_loop  input  1  raw asynchronous sensor, vehicle waiting at the exit gate.
REQ-008 exit_beam  input  1  raw asynchronous sensor, beam past the exit barrier broken.
REQ-009 parking_full  input  1  synchronous occupancy-full flag from the occupancy counter.
REQ-010 entry_gate_open  output  1  entry barrier raise command, registered.
REQ-011 exit_gate_open  output  1  exit barrier raise command, registered.
REQ-012 entry_event  output  1  one-cycle pulse per completed entry; drives the counter's entry sensor input.
REQ-013 exit_event  output  1  one-cycle pulse per completed exit; drives the counter's exit sensor input.
REQ-014 entry_denied  output  1  level, entry vehicle waiting while lot is full.

Function
REQ-015 Each raw sensor SHALL pass through a 2-flop synchronizer, then a per-sensor debouncer. The debouncer's stable counter resets whenever the synchronized value equals the debounced value. The debounced value toggles on the edge where the synchronized value has differed for DEBOUNCE_CYCLES consecutive cycles.
REQ-016 Raw-to-debounced latency SHALL be exactly DEBOUNCE_CYCLES+2 edges; any glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no debounced change.
REQ-017 Each lane SHALL run an independent FSM with states IDLE, OPEN, PASSING, CLOSING; gate_open SHALL be high exactly in OPEN and PASSING.
REQ-018 Entry IDLE->OPEN SHALL occur when debounced entry_loop=1 and parking_full=0. Exit IDLE->OPEN SHALL occur when debounced exit_loop=1, regardless of parking_full.
REQ-019 OPEN->PASSING SHALL occur when the lane's debounced beam=1. OPEN->CLOSING SHALL occur when the OPEN dwell counter reaches OPEN_TIMEOUT with beam still 0 (timeout, no event).
REQ-020 PASSING->CLOSING SHALL occur when the debounced beam returns to 0, and the lane's event output SHALL pulse high for exactly the one cycle following that transition edge. PASSING has no timeout.
REQ-021 CLOSING->IDLE SHALL occur only when debounced loop=0, so a vehicle lingering on the loop cannot produce a second event.
REQ-022 The dwell counter SHALL be $clog2(OPEN_TIMEOUT+1) bits wide, cleared on entry to OPEN, incremented each OPEN cycle, and never wrap.
REQ-023 parking_full SHALL be evaluated only in entry IDLE; a rise of parking_full during OPEN/PASSING SHALL NOT close the gate or suppress the event.
REQ-024 entry_denied SHALL equal (entry FSM in IDLE) AND debounced entry_loop AND parking_full, registered (one-cycle delay).
REQ-025 A beam asserting while its lane is in IDLE or CLOSING (tailgate or reversing vehicle) SHALL be ignored: no state change, no event.
REQ-026 Entry and exit events in the same cycle SHALL both be emitted; there is no arbitration between lanes.

Reset
REQ-027 While rst=1, all FSMs SHALL be in IDLE, and all synchronizer, debounced, and counter registers and all outputs SHALL be 0, asynchronously.
REQ-028 Reset asserted mid-operation (any state, including PASSING) SHALL drop gate_open immediately and emit no event; after release, a lane SHALL reopen only via a fresh debounced loop assertion.

Verification (DEBOUNCE_CYCLES=4, OPEN_TIMEOUT=20)
REQ-029 Normal entry: entry_loop=1, parking_full=0 -> entry_gate_open rises 7 edges later. Then entry_beam=1 for 10 cycles and back to 0 -> exactly one entry_event pulse. Then entry_loop=0 -> FSM back in IDLE.
REQ-030 Full lot: parking_full=1, entry_loop=1 -> entry_gate_open stays 0 and entry_denied=1. Then parking_full drops to 0 -> gate opens on the next edge and entry_denied=0.
REQ-031 Timeout: exit_loop=1 with exit_beam held 0 -> exit_gate_open is high for exactly 20 cycles, then falls, and no exit_event is emitted.
REQ-032 Glitch rejection: 3-cycle pulses on entry_loop and entry_beam -> no gate open and no event. A 3-cycle dropout of entry_beam during PASSING -> still exactly one entry_event.
REQ-033 Simultaneous and reset: both lanes complete in the same cycle -> entry_event and exit_event both pulse. Then rst asserted during PASSING -> gates=0, no events, and all outputs 0 after release.
